// File: rtl/ball_pkg.sv
// Shared types and geometry for the ball motion controller.
package ball_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SPAWN = 2'd1,
    MOVE  = 2'd2,
    WAIT  = 2'd3
  } state_t;

  localparam int unsigned SCREEN_W  = 640;
  localparam int unsigned BALL_W    = 8;
  localparam int unsigned SPAWN_COL = SCREEN_W - BALL_W;
  localparam int unsigned POS_W     = 16;
  localparam int unsigned LFSR_W    = 6;

endpackage

// File: rtl/ball_lfsr.sv
// 6-bit Fibonacci LFSR, polynomial x^6+x^5+1, free-running every clock.
module ball_lfsr
  import ball_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 6'h01
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [LFSR_W-1:0] out
);

  // Seed must be non-zero; the all-zero state is a lock-up state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out <= SEED;
    else        out <= {out[LFSR_W-2:0], out[LFSR_W-1] ^ out[LFSR_W-2]};
  end

endmodule

// File: rtl/ball_motion.sv
// Per-frame ball position, respawn and scoring controller.
// Optional BALL_SPEEDUP_EN: horizontal step grows by one every 8th scored hit.
module ball_motion
  import ball_pkg::*;
#(
  parameter int unsigned SPAWN_COL      = ball_pkg::SPAWN_COL,
  parameter int unsigned HSPEED         = 2,
  parameter int unsigned VSPEED         = 1,
  parameter int unsigned RESPAWN_FRAMES = 30,
  parameter logic [5:0]  LFSR_SEED      = 6'h01
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame,
  input  logic        start,
  input  logic        down_ok,
  input  logic        new_ball,
  input  logic [15:0] new_ball_row,
  input  logic        hit,
  output logic [15:0] ball_row,
  output logic [15:0] ball_col,
  output logic [5:0]  rng_row,
  output logic        active,
  output logic        hit_pulse,
  output logic        miss_pulse,
  output logic [7:0]  score
);

  localparam int          CNT_W   = $clog2(RESPAWN_FRAMES + 1);
  localparam logic [15:0] SPAWN_C = 16'(SPAWN_COL);
  localparam logic [15:0] VSTEP   = 16'(VSPEED);

  state_t           state, state_n;
  logic [15:0]      row_n, col_n, step;
  logic [7:0]       score_n;
  logic             hit_latch, hit_latch_n;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_n;
  logic             active_n, hit_pulse_n, miss_pulse_n;

`ifdef BALL_SPEEDUP_EN
  logic [2:0] cur_speed, cur_speed_n;
  assign step = {13'd0, cur_speed};
`else
  assign step = 16'(HSPEED);
`endif

  ball_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .out   (rng_row)
  );

  always_comb begin
    state_n      = state;
    row_n        = ball_row;
    col_n        = ball_col;
    score_n      = score;
    wait_cnt_n   = wait_cnt;
    hit_pulse_n  = 1'b0;
    miss_pulse_n = 1'b0;
`ifdef BALL_SPEEDUP_EN
    cur_speed_n  = cur_speed;
`endif
    // Frame clears first so a hit coincident with frame counts for the next frame.
    hit_latch_n = hit_latch;
    if (frame)                 hit_latch_n = 1'b0;
    if (hit && state == MOVE)  hit_latch_n = 1'b1;

    case (state)
      IDLE: begin
        col_n = SPAWN_C;
        if (start) state_n = SPAWN;
      end
      SPAWN: begin
        row_n   = new_ball_row;
        col_n   = SPAWN_C;
        state_n = MOVE;
      end
      MOVE: begin
        if (frame) begin
          if (hit_latch) begin
            if (score != 8'hFF) score_n = score + 8'd1;
            hit_pulse_n = 1'b1;
            state_n     = SPAWN;
`ifdef BALL_SPEEDUP_EN
            if (score != 8'hFF && score_n[2:0] == 3'd0 && cur_speed != 3'd7)
              cur_speed_n = cur_speed + 3'd1;
`endif
          end else if (new_ball) begin
            miss_pulse_n = 1'b1;
            wait_cnt_n   = '0;
            state_n      = WAIT;
          end else begin
            col_n = (ball_col > step) ? ball_col - step : 16'd0;
            if (down_ok) row_n = ball_row + VSTEP;
          end
        end
      end
      WAIT: begin
        if (frame) begin
          if (wait_cnt == CNT_W'(RESPAWN_FRAMES - 1)) begin
            wait_cnt_n = '0;
            state_n    = SPAWN;
          end else begin
            wait_cnt_n = wait_cnt + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    active_n = (state_n == MOVE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ball_row   <= 16'd0;
      ball_col   <= SPAWN_C;
      score      <= 8'd0;
      hit_latch  <= 1'b0;
      wait_cnt   <= '0;
      active     <= 1'b0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
`ifdef BALL_SPEEDUP_EN
      cur_speed  <= 3'(HSPEED);
`endif
    end else begin
      state      <= state_n;
      ball_row   <= row_n;
      ball_col   <= col_n;
      score      <= score_n;
      hit_latch  <= hit_latch_n;
      wait_cnt   <= wait_cnt_n;
      active     <= active_n;
      hit_pulse  <= hit_pulse_n;
      miss_pulse <= miss_pulse_n;
`ifdef BALL_SPEEDUP_EN
      cur_speed  <= cur_speed_n;
`endif
    end
  end

endmodule

// File: tb/tb_ball_motion.sv
// Directed, table-driven bench for ball_motion (default and BALL_SPEEDUP_EN builds).
module tb_ball_motion;

  logic        clk = 1'b0;
  logic        rst_n, frame, start, down_ok, new_ball, hit;
  logic [15:0] new_ball_row, ball_row, ball_col;
  logic [5:0]  rng_row;
  logic        active, hit_pulse, miss_pulse;
  logic [7:0]  score;

  int errors = 0;
  int checks = 0;
  int hits_done = 0;

  always #5 clk = ~clk;

  ball_motion dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame        (frame),
    .start        (start),
    .down_ok      (down_ok),
    .new_ball     (new_ball),
    .new_ball_row (new_ball_row),
    .hit          (hit),
    .ball_row     (ball_row),
    .ball_col     (ball_col),
    .rng_row      (rng_row),
    .active       (active),
    .hit_pulse    (hit_pulse),
    .miss_pulse   (miss_pulse),
    .score        (score)
  );

  typedef struct {
    logic        frame, start, down_ok, new_ball, hit;
    logic [15:0] nbr;
    logic [15:0] exp_row, exp_col;
    logic        exp_active, exp_hit, exp_miss;
    logic [7:0]  exp_score;
  } vec_t;

  vec_t vecs[10];

  function automatic int exp_step(int h);
`ifdef BALL_SPEEDUP_EN
    int s = 2 + h / 8;
    return (s > 7) ? 7 : s;
`else
    return 2;
`endif
  endfunction

  function automatic logic [5:0] lfsr_model(logic [5:0] x);
    return {x[4:0], x[5] ^ x[4]};
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drive one clock's worth of inputs, then sample 1ns after the edge.
  task automatic applyStimulus(input logic f, input logic s, input logic d,
                               input logic nb, input logic h, input logic [15:0] nbr);
    frame = f; start = s; down_ok = d; new_ball = nb; hit = h; new_ball_row = nbr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_row"},    ball_row,   0);
    checkOutput({tag, "_col"},    ball_col,   632);
    checkOutput({tag, "_score"},  score,      0);
    checkOutput({tag, "_active"}, active,     0);
    checkOutput({tag, "_hitp"},   hit_pulse,  0);
    checkOutput({tag, "_missp"},  miss_pulse, 0);
    checkOutput({tag, "_rng"},    rng_row,    1);
  endtask

  initial begin
    logic [5:0] exp_rng;
    bit         seen[64];
    int         distinct;
    int         exp_col;

    rst_n = 1'b0; frame = 0; start = 0; down_ok = 0; new_ball = 0; hit = 0;
    new_ball_row = 16'd0;
    repeat (2) @(posedge clk);
    #2;
    checkReset("reset");
    rst_n = 1'b1;

    // LFSR sequence from the seed: 63 distinct non-zero states, then repeat.
    exp_rng = 6'h01;
    distinct = 0;
    foreach (seen[i]) seen[i] = 1'b0;
    seen[1] = 1'b1;
    distinct = 1;
    for (int i = 1; i <= 63; i++) begin
      @(posedge clk);
      #1;
      exp_rng = lfsr_model(exp_rng);
      checkOutput($sformatf("lfsr_%0d", i), rng_row, exp_rng);
      if (i < 63) begin
        if (rng_row != 6'd0 && !seen[rng_row]) distinct++;
        seen[rng_row] = 1'b1;
      end
    end
    checkOutput("lfsr_distinct", distinct, 63);
    checkOutput("lfsr_wrap", rng_row, 1);
    checkOutput("idle_col", ball_col, 632);

    // Start, spawn, move with/without down_ok, ignored start, miss.
    vecs[0] = '{1'b0,1'b1,1'b0,1'b0,1'b0,16'd300, 16'd0,  16'd632,1'b0,1'b0,1'b0,8'd0};
    vecs[1] = '{1'b0,1'b0,1'b0,1'b0,1'b0,16'd300, 16'd300,16'd632,1'b1,1'b0,1'b0,8'd0};
    vecs[2] = '{1'b1,1'b0,1'b1,1'b0,1'b0,16'd300, 16'd301,16'd630,1'b1,1'b0,1'b0,8'd0};
    vecs[3] = '{1'b0,1'b0,1'b1,1'b0,1'b0,16'd300, 16'd301,16'd630,1'b1,1'b0,1'b0,8'd0};
    vecs[4] = '{1'b1,1'b0,1'b1,1'b0,1'b0,16'd300, 16'd302,16'd628,1'b1,1'b0,1'b0,8'd0};
    vecs[5] = '{1'b1,1'b0,1'b1,1'b0,1'b0,16'd300, 16'd303,16'd626,1'b1,1'b0,1'b0,8'd0};
    vecs[6] = '{1'b1,1'b0,1'b0,1'b0,1'b0,16'd300, 16'd303,16'd624,1'b1,1'b0,1'b0,8'd0};
    vecs[7] = '{1'b0,1'b1,1'b0,1'b0,1'b0,16'd300, 16'd303,16'd624,1'b1,1'b0,1'b0,8'd0};
    vecs[8] = '{1'b1,1'b0,1'b0,1'b1,1'b0,16'd300, 16'd303,16'd624,1'b0,1'b0,1'b1,8'd0};
    vecs[9] = '{1'b0,1'b0,1'b0,1'b0,1'b0,16'd300, 16'd303,16'd624,1'b0,1'b0,1'b0,8'd0};
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].frame, vecs[i].start, vecs[i].down_ok,
                    vecs[i].new_ball, vecs[i].hit, vecs[i].nbr);
      checkOutput($sformatf("v%0d_row", i),    ball_row,   vecs[i].exp_row);
      checkOutput($sformatf("v%0d_col", i),    ball_col,   vecs[i].exp_col);
      checkOutput($sformatf("v%0d_active", i), active,     vecs[i].exp_active);
      checkOutput($sformatf("v%0d_hitp", i),   hit_pulse,  vecs[i].exp_hit);
      checkOutput($sformatf("v%0d_missp", i),  miss_pulse, vecs[i].exp_miss);
      checkOutput($sformatf("v%0d_score", i),  score,      vecs[i].exp_score);
    end

    // WAIT: 29 frames frozen (hit ignored), respawn on the 30th.
    for (int i = 1; i <= 29; i++) begin
      applyStimulus(1, 0, 1, 0, 1, 16'd500);
      checkOutput($sformatf("wait%0d_col", i), ball_col, 624);
      checkOutput($sformatf("wait%0d_row", i), ball_row, 303);
      checkOutput($sformatf("wait%0d_missp", i), miss_pulse, 0);
      applyStimulus(0, 0, 1, 0, 1, 16'd500);
      checkOutput($sformatf("wait%0d_active", i), active, 0);
    end
    applyStimulus(1, 0, 0, 0, 0, 16'd500);
    checkOutput("wait30_active", active, 0);
    applyStimulus(0, 0, 0, 0, 0, 16'd500);
    checkOutput("respawn_active", active, 1);
    checkOutput("respawn_row", ball_row, 500);
    checkOutput("respawn_col", ball_col, 632);
    checkOutput("respawn_score", score, 0);

    // Hit held 50 clks plus new_ball in the same frame: hit wins.
    repeat (50) applyStimulus(0, 0, 0, 0, 1, 16'd500);
    applyStimulus(1, 0, 0, 1, 0, 16'd500);
    hits_done = 1;
    checkOutput("hitwin_hitp", hit_pulse, 1);
    checkOutput("hitwin_missp", miss_pulse, 0);
    checkOutput("hitwin_score", score, 1);
    checkOutput("hitwin_active", active, 0);
    applyStimulus(0, 0, 0, 0, 0, 16'd700);
    checkOutput("hitwin_once", hit_pulse, 0);
    checkOutput("hitwin_spawn_row", ball_row, 700);
    checkOutput("hitwin_spawn_active", active, 1);

    // Hit coincident with frame is deferred to the next frame.
    applyStimulus(1, 0, 1, 0, 1, 16'd700);
    checkOutput("sameclk_hitp", hit_pulse, 0);
    checkOutput("sameclk_col", ball_col, 632 - exp_step(1));
    checkOutput("sameclk_row", ball_row, 701);
    applyStimulus(1, 0, 0, 0, 0, 16'd700);
    hits_done = 2;
    checkOutput("deferred_hitp", hit_pulse, 1);
    checkOutput("deferred_score", score, 2);
    applyStimulus(0, 0, 0, 0, 0, 16'd100);
    checkOutput("deferred_spawn_row", ball_row, 100);

    // Score saturation and per-frame step after each hit.
    while (hits_done < 256) begin
      applyStimulus(0, 0, 0, 0, 1, 16'd100);
      applyStimulus(1, 0, 0, 0, 0, 16'd100);
      hits_done++;
      checkOutput($sformatf("sat%0d_hitp", hits_done), hit_pulse, 1);
      checkOutput($sformatf("sat%0d_score", hits_done), score,
                  (hits_done > 255) ? 255 : hits_done);
      applyStimulus(0, 0, 0, 0, 0, 16'd100);
      applyStimulus(1, 0, 0, 0, 0, 16'd100);
      checkOutput($sformatf("sat%0d_step", hits_done), ball_col, 632 - exp_step(hits_done));
    end

    // Column floors at zero instead of wrapping.
    exp_col = 632 - exp_step(hits_done);
    for (int i = 0; i < 330; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 16'd100);
      exp_col = (exp_col > exp_step(hits_done)) ? exp_col - exp_step(hits_done) : 0;
      checkOutput($sformatf("floor%0d_col", i), ball_col, exp_col);
    end
    checkOutput("floor_row", ball_row, 100);

    // Asynchronous reset while in WAIT.
    applyStimulus(1, 0, 0, 1, 0, 16'd100);
    checkOutput("prewait_missp", miss_pulse, 1);
    applyStimulus(0, 0, 0, 0, 0, 16'd100);
    #2 rst_n = 1'b0;
    #1 checkReset("rst_wait");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Asynchronous reset while in MOVE.
    applyStimulus(0, 1, 0, 0, 0, 16'd42);
    applyStimulus(0, 0, 0, 0, 0, 16'd42);
    checkOutput("move2_row", ball_row, 42);
    applyStimulus(0, 0, 0, 0, 1, 16'd42);
    applyStimulus(1, 0, 0, 0, 0, 16'd42);
    checkOutput("move2_score", score, 1);
    applyStimulus(0, 0, 0, 0, 0, 16'd42);
    applyStimulus(1, 0, 1, 0, 0, 16'd42);
    checkOutput("move2_col", ball_col, 630);
    checkOutput("move2_rowstep", ball_row, 43);
    #2 rst_n = 1'b0;
    #1 checkReset("rst_move");
    @(negedge clk) rst_n = 1'b1;
    repeat (3) applyStimulus(1, 0, 1, 0, 0, 16'd42);
    checkOutput("post_rst_idle_active", active, 0);
    checkOutput("post_rst_idle_col", ball_col, 632);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
